// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, SubBytes engine state encoding,
// and the FIPS-197 byte-position helper.
package aes_pkg;

    localparam int AES_BLOCK_BITS = 128;
    localparam int AES_BYTES      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sb_state_e;

    // Byte k sits at bits [127-8k -: 8], so its LSB is at 120-8k.
    function automatic int byte_lsb(input int k);
        return AES_BLOCK_BITS - 8 * (k + 1);
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box (FIPS-197), purely combinational lookup.
// Mirrors the decrypt-path inverse S-box.
module sbox (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam logic [7:0] FWD_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign data_out = FWD_TABLE[data_in];

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: LANES bytes per cycle through LANES S-boxes,
// one 128-bit state in and out over valid/ready handshakes.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLOCK_BITS-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_BLOCK_BITS-1:0] data_out
);

    localparam int STEPS = AES_BYTES / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sb_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [AES_BLOCK_BITS-1:0] work_q, work_next;
    logic                      out_load;
    logic [7:0]                sbox_in  [LANES];
    logic [7:0]                sbox_out [LANES];

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            sbox u_sbox (
                .data_in  (sbox_in[g]),
                .data_out (sbox_out[g])
            );
        end
    endgenerate

    // Lane g handles byte cnt*LANES+g of the current step.
    always_comb begin
        for (int g = 0; g < LANES; g++) begin
            sbox_in[g] = work_q[byte_lsb(int'(cnt_q) * LANES + g) +: 8];
        end
    end

    always_comb begin
        work_next = work_q;
        for (int g = 0; g < LANES; g++) begin
            work_next[byte_lsb(int'(cnt_q) * LANES + g) +: 8] = sbox_out[g];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path through it leaves a signal unassigned (which would infer a latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_load  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    out_load = 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_out <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (out_load) begin
                data_out <= work_next;
            end
        end
    end

    // NOTE: the work register has no reset; it is always loaded from data_in
    // before any of its contents can reach data_out.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && in_valid) begin
            work_q <= data_in;
        end else if (state_q == ST_BUSY) begin
            work_q <= work_next;
        end
    end

endmodule
